// File: rtl/reg_file_l1.sv
// ============================================================================
// Module   : reg_file_l1
// Purpose  : Operand register file; MSB-set addresses spill to a backing RAM
//            over a req/ack handshake, with busy/op_done for decode stalls.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_l1 #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_W     = 5,
  parameter int RESET_INIT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              prog_mode,
  input  logic              op_valid,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              RUWr,
  input  logic [XLEN-1:0]   DataWr,
  output logic [XLEN-1:0]   RUrs1,
  output logic [XLEN-1:0]   RUrs2,
  output logic              busy,
  output logic              op_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int IDX_W  = ADDR_W - 1;
  localparam int REG_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH1 = 3'd1;
  localparam logic [2:0] S_FETCH2 = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic              clr;
  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic              accept;

  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic              we_q;
  logic [XLEN-1:0]   wdata_q;

  logic [XLEN-1:0]   regs [NUM_REGS];

  logic              rs1_ok;
  logic              rs2_ok;
  logic              rd_ok;
  logic [XLEN-1:0]   rs1_local;
  logic [XLEN-1:0]   rs2_local;

  logic              need_f1_in;
  logic              need_f2_in;
  logic              need_st_in;
  logic              same_q;
  logic              need_f2_q;
  logic              need_st_q;
  logic              write_local;

  assign clr    = RESET | prog_mode;
  assign accept = (state == S_IDLE) && op_valid;

  // Index range check only exists when the local file is smaller than the
  // local half of the address space.
  generate
    if (REG_AW < IDX_W) begin : g_range
      assign rs1_ok = (rs1[IDX_W-1:REG_AW] == '0);
      assign rs2_ok = (rs2[IDX_W-1:REG_AW] == '0);
      assign rd_ok  = (rd_q[IDX_W-1:REG_AW] == '0);
    end else begin : g_full
      assign rs1_ok = 1'b1;
      assign rs2_ok = 1'b1;
      assign rd_ok  = 1'b1;
    end
  endgenerate

  assign rs1_local = (!rs1[ADDR_W-1] && rs1_ok) ? regs[rs1[REG_AW-1:0]] : '0;
  assign rs2_local = (!rs2[ADDR_W-1] && rs2_ok) ? regs[rs2[REG_AW-1:0]] : '0;

  // A remote rs2 identical to a remote rs1 is served by the FETCH1 data.
  assign need_f1_in = rs1[ADDR_W-1];
  assign need_f2_in = rs2[ADDR_W-1] && !(rs1[ADDR_W-1] && (rs1 == rs2));
  assign need_st_in = RUWr && rd[ADDR_W-1];

  assign same_q    = rs1_q[ADDR_W-1] && rs2_q[ADDR_W-1] && (rs1_q == rs2_q);
  assign need_f2_q = rs2_q[ADDR_W-1] && !same_q;
  assign need_st_q = we_q && rd_q[ADDR_W-1];

  assign write_local = we_q && !rd_q[ADDR_W-1] && rd_ok && (rd_q[IDX_W-1:0] != '0);

  // State register
  always_ff @(posedge CLK) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          if (need_f1_in)      state_nx = S_FETCH1;
          else if (need_f2_in) state_nx = S_FETCH2;
          else if (need_st_in) state_nx = S_STORE;
          else                 state_nx = S_DONE;
        end
      end
      S_FETCH1: begin
        if (mem_ack) begin
          if (need_f2_q)      state_nx = S_FETCH2;
          else if (need_st_q) state_nx = S_STORE;
          else                state_nx = S_DONE;
        end
      end
      S_FETCH2: begin
        if (mem_ack) begin
          if (need_st_q) state_nx = S_STORE;
          else           state_nx = S_DONE;
        end
      end
      S_STORE: begin
        if (mem_ack) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output logic; request fields come from latched operands so they stay
  // stable for the whole handshake.
  always_comb begin
    busy      = (state != S_IDLE);
    op_done   = (state == S_DONE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_FETCH1: begin
        mem_req  = 1'b1;
        mem_addr = rs1_q[IDX_W-1:0];
      end
      S_FETCH2: begin
        mem_req  = 1'b1;
        mem_addr = rs2_q[IDX_W-1:0];
      end
      S_STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = rd_q[IDX_W-1:0];
        mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Operand latches and result registers
  always_ff @(posedge CLK) begin
    if (clr) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      RUrs1   <= '0;
      RUrs2   <= '0;
    end else begin
      if (accept) begin
        rs1_q   <= rs1;
        rs2_q   <= rs2;
        rd_q    <= rd;
        we_q    <= RUWr;
        wdata_q <= DataWr;
        RUrs1   <= rs1_local;
        RUrs2   <= rs2_local;
      end
      if ((state == S_FETCH1) && mem_ack) begin
        RUrs1 <= mem_rdata;
        if (same_q) RUrs2 <= mem_rdata;
      end
      if ((state == S_FETCH2) && mem_ack) begin
        RUrs2 <= mem_rdata;
      end
    end
  end

  // Local register array; a write lands on the edge leaving DONE so the
  // operation's own operands always see the pre-write contents.
  always_ff @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (RESET_INIT != 0) ? XLEN'(i) : '0;
      end
    end else if ((state == S_DONE) && write_local) begin
      regs[rd_q[REG_AW-1:0]] <= wdata_q;
    end
  end

endmodule

`default_nettype wire
